req_priority_encoder: RTL



---
 rtl/req_priority_encoder.sv | 106 ++++++++++
 1 files changed

// File: rtl/req_priority_encoder.sv
// Sequential N-to-log2(N) priority encoder. Requests are latched into a pending
// register. One binary index is handed out per valid/ready transfer, highest
// index first, and each served bit is cleared on its transfer edge.
module req_priority_encoder #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_code,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] pending,
    output logic         overflow
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e       state_q;
    logic [W-1:0] code_q;
    logic         valid_q;
    logic [N-1:0] pending_q, pending_d;
    logic         overflow_q, overflow_d;

    logic         transfer;
    logic [N-1:0] served_mask;
    logic [N-1:0] rem;
    logic [N-1:0] captured;

    // Highest set index of v. An all-zero vector returns 0, but callers only
    // use the result when v is non-zero.
    function automatic logic [W-1:0] top_index(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    // Served-bit mask, remaining requests and next pending/overflow values.
    // rem deliberately excludes same-cycle requests, so a request arriving on a
    // transfer edge is issued no earlier than the following edge.
    always_comb begin
        transfer    = valid_q & out_ready;
        served_mask = '0;
        if (transfer) served_mask = N'(1) << code_q;
        rem         = pending_q & ~served_mask;
        captured    = enable ? req : '0;
        pending_d   = rem | captured;
        overflow_d  = |(captured & rem);
    end

    // Pending register and the one-cycle overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Presentation FSM. The code is held until its transfer edge; enable only
    // gates new issues, never an issue already presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable && (pending_q != '0)) begin
                        code_q  <= top_index(pending_q);
                        valid_q <= 1'b1;
                        state_q <= StPresent;
                    end
                end
                StPresent: begin
                    if (transfer) begin
                        if (enable && (rem != '0)) begin
                            code_q <= top_index(rem);
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_code  = code_q;
    assign out_valid = valid_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
